mesh_lane_deskew: RTL and testbench

- Receive-side companion to the mesh pipe array. Lanes crossing the mesh traverse pipe segments of unequal depth (LSB/MID/MSB endpieces), so words launched together arrive skewed.
- This block buffers each lane in a small per-lane FIFO and releases one aligned multi-lane word only when every lane holds data.
- Sits at the far end of a mesh pipe array, ahead of the consuming datapath.
- No backpressure exists; pipe stages cannot stall.

---
 rtl/mesh_lane_deskew.sv | 127 ++++++++++++
 tb/tb_mesh_lane_deskew.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_lane_deskew.sv
// Receive-side lane deskew: per-lane FIFOs absorb mesh pipe skew and release one
// aligned multi-lane word whenever every lane holds at least one entry.

module mesh_lane_deskew_lane #(
  parameter int WIDTH      = 36,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic [ADDR_WIDTH:0]   o_count_nxt,
  output logic                  o_overflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH+1)'(FIFO_DEPTH - 1);

  logic [WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] r_wptr, r_rptr, r_count;
  logic [ADDR_WIDTH:0] w_count_nxt;
  logic                r_overflow;
  logic                w_full, w_wr;

  // A full lane still accepts a push when the same edge pops it.
  assign w_full = (r_count == DEPTH_C);
  assign w_wr   = i_push && (!w_full || i_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !i_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_wr && i_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + 1'b1;
      if (i_pop) r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + 1'b1;
      r_count <= w_count_nxt;
      if (i_push && w_full && !i_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= i_din;
  end

  assign o_dout      = r_mem[r_rptr[ADDR_WIDTH-1:0]];
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_overflow  = r_overflow;
endmodule

module mesh_lane_deskew #(
  parameter int WIDTH      = 36,
  parameter int LANE_COUNT = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [LANE_COUNT-1:0]       i_in_valid,
  input  logic [WIDTH*LANE_COUNT-1:0] i_in,
  output logic                        o_out_valid,
  output logic [WIDTH*LANE_COUNT-1:0] o_out,
  output logic [LANE_COUNT-1:0]       o_overflow,
  output logic [ADDR_WIDTH:0]         o_occupancy_max
);
  logic [LANE_COUNT-1:0][WIDTH-1:0]    w_dout;
  logic [LANE_COUNT-1:0][ADDR_WIDTH:0] w_count, w_count_nxt;
  logic [LANE_COUNT-1:0]               w_nonempty;
  logic                                w_pop;
  logic [ADDR_WIDTH:0]                 w_occ_max;
  logic                                r_out_valid;
  logic [WIDTH*LANE_COUNT-1:0]         r_out;
  logic [ADDR_WIDTH:0]                 r_occ_max;

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    mesh_lane_deskew_lane #(
      .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_push     (i_in_valid[g]),
      .i_pop      (w_pop),
      .i_din      (i_in[g*WIDTH +: WIDTH]),
      .o_dout     (w_dout[g]),
      .o_count    (w_count[g]),
      .o_count_nxt(w_count_nxt[g]),
      .o_overflow (o_overflow[g])
    );
    assign w_nonempty[g] = |w_count[g];
  end

  // Pop decision uses registered counts only, so a word written this edge pops next edge.
  assign w_pop = &w_nonempty;

  always_comb begin
    w_occ_max = '0;
    for (int i = 0; i < LANE_COUNT; i++)
      if (w_count_nxt[i] > w_occ_max) w_occ_max = w_count_nxt[i];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_occ_max   <= '0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop) r_out <= w_dout;
      r_occ_max   <= w_occ_max;
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_out           = r_out;
  assign o_occupancy_max = r_occ_max;
endmodule

// File: tb/tb_mesh_lane_deskew.sv
// Directed bench for mesh_lane_deskew: vector table for aligned/skewed/full/overflow
// streams, plus hand sequences for mid-stream reset and narrow lane packing.

module tb_mesh_lane_deskew;
  localparam int W = 36;
  localparam int L = 4;

  typedef struct {
    logic [L-1:0]        vld;
    logic [L-1:0][W-1:0] din;
    logic                ov;
    logic                chk_out;
    logic [L-1:0][W-1:0] out;
    logic [L-1:0]        ovf;
    logic [2:0]          occ;
    string               name;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [L-1:0]      in_valid = '0;
  logic [W*L-1:0]    in_data = '0;
  logic              out_valid;
  logic [W*L-1:0]    out_data;
  logic [L-1:0]      overflow;
  logic [2:0]        occ_max;

  logic [1:0]        in_valid2 = '0;
  logic [15:0]       in_data2 = '0;
  logic              out_valid2;
  logic [15:0]       out_data2;
  logic [1:0]        overflow2;
  logic [2:0]        occ_max2;

  int n_chk = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mesh_lane_deskew #(.WIDTH(W), .LANE_COUNT(L), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .i_in(in_data),
    .o_out_valid(out_valid), .o_out(out_data), .o_overflow(overflow),
    .o_occupancy_max(occ_max)
  );

  mesh_lane_deskew #(.WIDTH(8), .LANE_COUNT(2), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid2), .i_in(in_data2),
    .o_out_valid(out_valid2), .o_out(out_data2), .o_overflow(overflow2),
    .o_occupancy_max(occ_max2)
  );

  task automatic chk(input string nm, input logic [W*L-1:0] act, input logic [W*L-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lw(input int tag, input int lane, input int n);
    return W'((tag << 12) | (lane << 8) | (n & 8'hff));
  endfunction

  function automatic logic [L-1:0][W-1:0] word(input int tag, input int n);
    logic [L-1:0][W-1:0] r;
    for (int i = 0; i < L; i++) r[i] = lw(tag, i, n);
    return r;
  endfunction

  task automatic add(input logic [L-1:0] vld, input logic [L-1:0][W-1:0] din, input logic ov,
                     input logic chk_out, input logic [L-1:0][W-1:0] out,
                     input logic [L-1:0] ovf, input logic [2:0] occ, input string name);
    vec_t v;
    v.vld = vld; v.din = din; v.ov = ov; v.chk_out = chk_out; v.out = out;
    v.ovf = ovf; v.occ = occ; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    in_valid = v.vld;
    in_data  = v.din;
    @(posedge clk);
    #1;
    chk({v.name, "_valid"}, W*L'(out_valid), W*L'(v.ov));
    chk({v.name, "_occ"},   W*L'(occ_max),   W*L'(v.occ));
    chk({v.name, "_ovf"},   W*L'(overflow),  W*L'(v.ovf));
    if (v.chk_out) chk({v.name, "_out"}, out_data, v.out);
  endtask

  initial begin
    logic [L-1:0][W-1:0] d, z, a;
    logic [L-1:0]        vl;
    int sk_occ[13] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0};
    int fl_occ[18] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0};
    int ov_occ[11] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0};
    z = '0;

    // Aligned arrival
    for (int i = 0; i < L; i++) a[i] = W'(36'h100 + i);
    add(4'hF, a, 1'b0, 1'b1, z, 4'h0, 3'd1, "align_e0");
    add(4'h0, z, 1'b1, 1'b1, a, 4'h0, 3'd0, "align_e1");
    add(4'h0, z, 1'b0, 1'b1, a, 4'h0, 3'd0, "align_hold");

    // Skewed arrival: lane 0 first, lanes 1/2 one cycle late, lane 3 three cycles late
    for (int e = 0; e < 13; e++) begin
      vl = '0;
      d  = '0;
      if (e <= 7)           begin vl[0] = 1'b1; d[0] = lw(1, 0, e); end
      if (e >= 1 && e <= 8) begin vl[1] = 1'b1; d[1] = lw(1, 1, e-1);
                                  vl[2] = 1'b1; d[2] = lw(1, 2, e-1); end
      if (e >= 3 && e <= 10) begin vl[3] = 1'b1; d[3] = lw(1, 3, e-3); end
      add(vl, d, (e >= 4 && e <= 11), (e >= 4 && e <= 11), word(1, e-4), 4'h0,
          3'(sk_occ[e]), $sformatf("skew_e%0d", e));
    end

    // Lane 0 leads by a full FIFO, then all lanes stream with simultaneous push/pop
    for (int e = 0; e < 18; e++) begin
      vl = '0;
      d  = '0;
      if (e <= 3)            begin vl[0] = 1'b1; d[0] = lw(2, 0, e); end
      if (e >= 5 && e <= 12) begin vl[0] = 1'b1; d[0] = lw(2, 0, e-1); end
      if (e >= 4 && e <= 15)
        for (int i = 1; i < L; i++) begin vl[i] = 1'b1; d[i] = lw(2, i, e-4); end
      add(vl, d, (e >= 5 && e <= 16), (e >= 5 && e <= 16), word(2, e-5), 4'h0,
          3'(fl_occ[e]), $sformatf("full_e%0d", e));
    end

    // Overflow: lane 0 pushed 5 times into a 4-deep FIFO, then lanes 1..3 catch up
    for (int e = 0; e < 11; e++) begin
      vl = '0;
      d  = '0;
      if (e <= 4) begin vl[0] = 1'b1; d[0] = lw(4, 0, e); end
      if (e >= 5 && e <= 8)
        for (int i = 1; i < L; i++) begin vl[i] = 1'b1; d[i] = lw(4, i, e-5); end
      add(vl, d, (e >= 6 && e <= 9), (e >= 6 && e <= 9), word(4, e-6),
          (e >= 4) ? 4'h1 : 4'h0, 3'(ov_occ[e]), $sformatf("ovf_e%0d", e));
    end

    // Reset state
    #12;
    chk("reset_valid", W*L'(out_valid), '0);
    chk("reset_out",   out_data,        '0);
    chk("reset_ovf",   W*L'(overflow),  '0);
    chk("reset_occ",   W*L'(occ_max),   '0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // Mid-stream reset: build counts of 2 with out_valid high, overflow still sticky
    @(negedge clk); in_valid = 4'b0111; in_data = word(5, 0);
    @(negedge clk); in_valid = 4'hF;    in_data = word(5, 1);
    @(negedge clk); in_valid = 4'hF;    in_data = word(5, 2);
    @(posedge clk); #1;
    chk("mid_pre_valid", W*L'(out_valid), W*L'(1));
    chk("mid_pre_occ",   W*L'(occ_max),   W*L'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", W*L'(out_valid), '0);
    chk("mid_rst_out",   out_data,        '0);
    chk("mid_rst_ovf",   W*L'(overflow),  '0);
    chk("mid_rst_occ",   W*L'(occ_max),   '0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'hF;
    in_data  = word(6, 9);
    @(posedge clk); #1;
    chk("post_rst_e0_valid", W*L'(out_valid), '0);
    chk("post_rst_e0_occ",   W*L'(occ_max),   W*L'(1));
    @(negedge clk); in_valid = '0; in_data = '0;
    @(posedge clk); #1;
    chk("post_rst_e1_valid", W*L'(out_valid), W*L'(1));
    chk("post_rst_e1_out",   out_data,        word(6, 9));
    @(posedge clk); #1;
    chk("post_rst_e2_valid", W*L'(out_valid), '0);
    chk("post_rst_e2_occ",   W*L'(occ_max),   '0);

    // Narrow lane packing
    @(negedge clk); in_valid2 = 2'b11; in_data2 = 16'hBBAA;
    @(negedge clk); in_valid2 = 2'b00; in_data2 = 16'h0000;
    @(posedge clk); #1;
    chk("pack_valid", W*L'(out_valid2),     W*L'(1));
    chk("pack_out",   W*L'(out_data2),      W*L'(16'hBBAA));
    chk("pack_lane0", W*L'(out_data2[7:0]), W*L'(8'hAA));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
